pll_reset_seq: RTL and testbench

//  Reset sequencer that consumes the iCE40 PLL lock output and runs in the PLL's global clock domain.

---
 rtl/pll_reset_seq_if.sv | 26 ++
 rtl/pll_reset_seq.sv | 138 +++++++++++++
 tb/tb_pll_reset_seq.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_seq_if.sv
// Lock / reset signal bundle between the PLL wrapper side (master) and pll_reset_seq (slave).
// loss_count and its width parameter exist only when RSTGEN_LOSS_CNT_EN is defined.
interface pll_reset_seq_if
`ifdef RSTGEN_LOSS_CNT_EN
  #(parameter int CNT_W = 8)
`endif
  ;
  logic       locked;
  logic       sw_rst_req;
  logic       soc_resetn;
  logic [1:0] rst_state;
  logic       lock_ok;
`ifdef RSTGEN_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_count;

  modport master (output locked, sw_rst_req,
                  input  soc_resetn, rst_state, lock_ok, loss_count);
  modport slave  (input  locked, sw_rst_req,
                  output soc_resetn, rst_state, lock_ok, loss_count);
`else
  modport master (output locked, sw_rst_req,
                  input  soc_resetn, rst_state, lock_ok);
  modport slave  (input  locked, sw_rst_req,
                  output soc_resetn, rst_state, lock_ok);
`endif
endinterface

// File: rtl/pll_reset_seq.sv
// PLL lock driven SoC reset sequencer: sync lock, wait for stable lock, filter loss, hold reset.
// Optional saturating lock-loss counter enabled by defining RSTGEN_LOSS_CNT_EN.
//
// state  | meaning
// WAIT   | reset held, waiting for synced lock
// STABLE | reset held, counting consecutive locked cycles
// RUN    | reset released, filtering lock loss, accepting sw requests
// HOLD   | reset held for a fixed time after loss or sw request
module pll_reset_seq #(
  parameter int LOCK_SYNC_STAGES = 2,
  parameter int STABLE_CYCLES    = 1024,
  parameter int HOLD_CYCLES      = 16,
  parameter int LOSS_FILTER      = 4
`ifdef RSTGEN_LOSS_CNT_EN
  , parameter int CNT_W          = 8
`endif
) (
  input logic             clk,
  input logic             resetn,
  pll_reset_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int STABLE_W = $clog2(STABLE_CYCLES) + 1;
  localparam int HOLD_W   = $clog2(HOLD_CYCLES) + 1;
  localparam int LOW_W    = $clog2(LOSS_FILTER) + 1;

  localparam logic [STABLE_W-1:0] STABLE_LOAD = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LOW_W-1:0]    LOW_LAST    = LOW_W'(LOSS_FILTER - 1);

  logic [LOCK_SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                      state_q, state_d;
  logic [STABLE_W-1:0]         stable_cnt_q, stable_cnt_d;
  logic [HOLD_W-1:0]           hold_cnt_q, hold_cnt_d;
  logic [LOW_W-1:0]            low_cnt_q, low_cnt_d;
  logic                        soc_resetn_q, soc_resetn_d;
  logic                        lock_ok;
  logic                        loss_evt;
`ifdef RSTGEN_LOSS_CNT_EN
  logic [CNT_W-1:0]            loss_count_q, loss_count_d;
`endif

  assign lock_ok = sync_q[LOCK_SYNC_STAGES-1];

  always_comb begin
    sync_d       = {sync_q[LOCK_SYNC_STAGES-2:0], bus.locked};
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    low_cnt_d    = '0;
    loss_evt     = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        if (lock_ok) begin
          state_d      = ST_STABLE;
          stable_cnt_d = STABLE_LOAD;
        end
      end
      ST_STABLE: begin
        if (!lock_ok) begin
          state_d      = ST_WAIT;
          stable_cnt_d = '0;
        end else if (stable_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          stable_cnt_d = stable_cnt_q - STABLE_W'(1);
        end
      end
      ST_RUN: begin
        // Loss fires on the edge that would make the low run reach LOSS_FILTER.
        loss_evt  = !lock_ok && (low_cnt_q == LOW_LAST);
        low_cnt_d = lock_ok ? '0 : low_cnt_q + LOW_W'(1);
        if (loss_evt || bus.sw_rst_req) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_LOAD;
          low_cnt_d  = '0;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = ST_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      default: state_d = ST_WAIT;
    endcase

    soc_resetn_d = (state_d == ST_RUN);

`ifdef RSTGEN_LOSS_CNT_EN
    loss_count_d = loss_count_q;
    if (loss_evt && (loss_count_q != {CNT_W{1'b1}})) begin
      loss_count_d = loss_count_q + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q       <= '0;
      state_q      <= ST_WAIT;
      stable_cnt_q <= '0;
      hold_cnt_q   <= '0;
      low_cnt_q    <= '0;
      soc_resetn_q <= 1'b0;
`ifdef RSTGEN_LOSS_CNT_EN
      loss_count_q <= '0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      low_cnt_q    <= low_cnt_d;
      soc_resetn_q <= soc_resetn_d;
`ifdef RSTGEN_LOSS_CNT_EN
      loss_count_q <= loss_count_d;
`endif
    end
  end

  assign bus.soc_resetn = soc_resetn_q;
  assign bus.rst_state  = state_q;
  assign bus.lock_ok    = lock_ok;
`ifdef RSTGEN_LOSS_CNT_EN
  assign bus.loss_count = loss_count_q;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed sequences plus randomized lock/sw/reset traffic
// compared each cycle against a cycle-age reference model. Loss counter checks need RSTGEN_LOSS_CNT_EN.
module tb_pll_reset_seq;
  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int HOLD   = 4;
  localparam int FILTER = 3;
  localparam int CW     = 8;

  localparam int M_WAIT = 0, M_STABLE = 1, M_RUN = 2, M_HOLD = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

`ifdef RSTGEN_LOSS_CNT_EN
  pll_reset_seq_if #(.CNT_W(CW)) bus ();
  pll_reset_seq #(.LOCK_SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD),
                  .LOSS_FILTER(FILTER), .CNT_W(CW))
    dut (.clk(clk), .resetn(resetn), .bus(bus));
`else
  pll_reset_seq_if bus ();
  pll_reset_seq #(.LOCK_SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD),
                  .LOSS_FILTER(FILTER))
    dut (.clk(clk), .resetn(resetn), .bus(bus));
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: synced lock is locked delayed by SYNC edges; each state tracks its age.
  bit hist[$];
  bit m_lock_ok;
  int m_state, m_age, m_low, m_loss;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC - 1; i++) hist.push_back(1'b0);
    m_lock_ok = 1'b0;
    m_state   = M_WAIT;
    m_age     = 0;
    m_low     = 0;
    m_loss    = 0;
  endtask

  task automatic model_edge(input logic rn, input logic lk, input logic sw);
    bit lo;
    bit lost;
    lo = m_lock_ok;
    if (!rn) begin
      model_reset();
      return;
    end
    hist.push_back(lk === 1'b1);
    m_lock_ok = hist.pop_front();
    case (m_state)
      M_WAIT:
        if (lo) begin m_state = M_STABLE; m_age = 0; end
      M_STABLE:
        if (!lo) m_state = M_WAIT;
        else begin
          m_age++;
          if (m_age == STABLE) begin m_state = M_RUN; m_low = 0; end
        end
      M_RUN: begin
        m_low = lo ? 0 : m_low + 1;
        lost  = (m_low == FILTER);
        if (lost && m_loss < (2**CW - 1)) m_loss++;
        if (lost || sw === 1'b1) begin m_state = M_HOLD; m_age = 0; m_low = 0; end
      end
      default: begin
        m_age++;
        if (m_age == HOLD) m_state = M_WAIT;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    chk("model_state", 32'(bus.rst_state), 32'(m_state));
    chk("model_soc_resetn", 32'(bus.soc_resetn), (m_state == M_RUN) ? 32'd1 : 32'd0);
    chk("model_lock_ok", 32'(bus.lock_ok), 32'(m_lock_ok));
`ifdef RSTGEN_LOSS_CNT_EN
    chk("model_loss_count", 32'(bus.loss_count), 32'(m_loss));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(resetn, bus.locked, bus.sw_rst_req);
    #1;
    compare_model();
  endtask

  task automatic chk_loss(input string tag, input int exp);
`ifdef RSTGEN_LOSS_CNT_EN
    chk(tag, 32'(bus.loss_count), 32'(exp));
`endif
  endtask

  initial begin
    int run_left;
    resetn         = 1'b0;
    bus.locked     = 1'b1;
    bus.sw_rst_req = 1'b0;

    // 1: reset then release with steady lock
    repeat (3) step();
    chk("t1_reset_soc", 32'(bus.soc_resetn), 0);
    chk("t1_reset_state", 32'(bus.rst_state), 0);
    chk("t1_reset_lock_ok", 32'(bus.lock_ok), 0);
    chk_loss("t1_reset_loss", 0);
    resetn = 1'b1;
    repeat (10) step();
    chk("t1_soc_edge10", 32'(bus.soc_resetn), 0);
    chk("t1_state_edge10", 32'(bus.rst_state), 1);
    step();
    chk("t1_soc_edge11", 32'(bus.soc_resetn), 1);
    chk("t1_state_edge11", 32'(bus.rst_state), 2);

    // 2: short unlock glitch is filtered
    bus.locked = 1'b0;
    repeat (2) step();
    bus.locked = 1'b1;
    repeat (6) step();
    chk("t2_soc_glitch", 32'(bus.soc_resetn), 1);
    chk("t2_state_glitch", 32'(bus.rst_state), 2);
    chk_loss("t2_loss", 0);

    // 3: sustained loss
    bus.locked = 1'b0;
    repeat (4) step();
    chk("t3_soc_edge4", 32'(bus.soc_resetn), 1);
    step();
    chk("t3_soc_edge5", 32'(bus.soc_resetn), 0);
    chk("t3_state_hold", 32'(bus.rst_state), 3);
    repeat (3) step();
    chk("t3_state_hold_last", 32'(bus.rst_state), 3);
    step();
    chk("t3_state_wait", 32'(bus.rst_state), 0);
    chk_loss("t3_loss", 1);
    bus.locked = 1'b1;
    repeat (11) step();
    chk("t3_relock_state", 32'(bus.rst_state), 2);

    // 5: software request
    bus.sw_rst_req = 1'b1;
    step();
    bus.sw_rst_req = 1'b0;
    chk("t5_hold_entry", 32'(bus.rst_state), 3);
    chk("t5_soc_low", 32'(bus.soc_resetn), 0);
    repeat (3) step();
    chk("t5_hold_last", 32'(bus.rst_state), 3);
    step();
    chk("t5_wait", 32'(bus.rst_state), 0);
    repeat (8) step();
    chk("t5_soc_before_release", 32'(bus.soc_resetn), 0);
    step();
    chk("t5_soc_release", 32'(bus.soc_resetn), 1);
    chk_loss("t5_loss_unchanged", 1);

    // loss and sw request on the same edge still count the loss
    bus.locked = 1'b0;
    repeat (4) step();
    bus.sw_rst_req = 1'b1;
    step();
    bus.sw_rst_req = 1'b0;
    bus.locked     = 1'b1;
    chk("t5b_state_hold", 32'(bus.rst_state), 3);
    chk_loss("t5b_loss_counted", 2);
    repeat (20) step();
    chk("t5b_relock_state", 32'(bus.rst_state), 2);

    // 4: reset mid-run, then lock drop during STABLE restarts the count
    resetn = 1'b0;
    step();
    chk("t4_reset_soc", 32'(bus.soc_resetn), 0);
    chk("t4_reset_state", 32'(bus.rst_state), 0);
    chk_loss("t4_reset_loss", 0);
    resetn = 1'b1;
    repeat (6) step();
    bus.locked = 1'b0;
    step();
    bus.locked = 1'b1;
    step();
    chk("t4_still_stable", 32'(bus.rst_state), 1);
    step();
    chk("t4_back_to_wait", 32'(bus.rst_state), 0);
    repeat (8) step();
    chk("t4_stable_before_run", 32'(bus.rst_state), 1);
    step();
    chk("t4_run", 32'(bus.rst_state), 2);
    chk("t4_soc", 32'(bus.soc_resetn), 1);

    // 6: saturate the loss counter, then reset clears it
    for (int n = 0; n < 300; n++) begin
      bus.locked = 1'b0;
      repeat (6) step();
      bus.locked = 1'b1;
      repeat (14) step();
    end
    chk("t6_state_run", 32'(bus.rst_state), 2);
    chk_loss("t6_loss_saturated", 255);
    resetn = 1'b0;
    step();
    chk("t6_reset_soc", 32'(bus.soc_resetn), 0);
    chk_loss("t6_reset_loss", 0);
    resetn = 1'b1;

    // randomized lock / sw / reset traffic against the model
    run_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        bus.locked = ~bus.locked;
        run_left   = bus.locked ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 8));
      end
      run_left--;
      bus.sw_rst_req = ($urandom_range(0, 29) == 0);
      resetn         = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
